// File: rtl/adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Chunk counter width; never below 1 so a single-chunk build still has a counter.
  function automatic int cnt_width(input int width, input int bpc);
    int w;
    w = $clog2(width / bpc);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/serial_adder_fa1.sv
// 1-bit full adder cell, purely combinational.
module FA1 (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial add/subtract, BPC bits per clock; result after WIDTH/BPC RUN cycles.
// start is only sampled when not busy; S/Cout/OVF hold until the next accept.
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BPC   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             SUB,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             OVF
);

  localparam int N  = WIDTH / BPC;
  localparam int CW = cnt_width(WIDTH, BPC);

  if (BPC < 1 || WIDTH < 2 || (WIDTH % BPC) != 0) begin : g_bad_param
    $error("serial_adder: WIDTH must be >= 2 and a multiple of BPC");
  end

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q, b_q, sh_q;
  logic [WIDTH-1:0] a_d, b_d, sh_d;
  logic [WIDTH-1:0] s_q;
  logic             cout_q, ovf_q, busy_q, done_q;

  logic [BPC:0]     c;
  logic [BPC-1:0]   sum;
  logic [WIDTH-1:0] sum_ext;
  logic             last;

  assign c[0] = carry_q;

  for (genvar i = 0; i < BPC; i++) begin : g_fa
    FA1 u_fa (
      .A   (a_q[i]),
      .B   (b_q[i]),
      .Cin (c[i]),
      .S   (sum[i]),
      .Cout(c[i+1])
    );
  end

  // Operands drain from the bottom; results enter the working register from the top.
  assign sum_ext = WIDTH'(sum);
  assign a_d     = a_q >> BPC;
  assign b_d     = b_q >> BPC;
  assign sh_d    = (sh_q >> BPC) | (sum_ext << (WIDTH - BPC));
  assign last    = (cnt_q == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sh_q    <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            // Subtract is A + ~B + 1: invert B once at capture, force carry-in.
            a_q     <= A;
            b_q     <= SUB ? ~B : B;
            carry_q <= SUB | Cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_q     <= a_d;
          b_q     <= b_d;
          sh_q    <= sh_d;
          carry_q <= c[BPC];
          cnt_q   <= cnt_q + CW'(1);
          if (last) begin
            s_q     <= sh_d;
            cout_q  <= c[BPC];
            ovf_q   <= c[BPC] ^ c[BPC-1];
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign S    = s_q;
  assign Cout = cout_q;
  assign OVF  = ovf_q;

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits; SHALL be >= 2.
REQ-002 Parameter BPC, default 1: bits processed per clock; SHALL divide WIDTH exactly (elaboration error otherwise).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  request new operation; sampled only when busy=0.
REQ-006 SUB  input  1  0 = add, 1 = subtract (A - B).
REQ-007 A  input  WIDTH  operand A, captured on accept.
REQ-008 B  input  WIDTH  operand B, captured on accept.
REQ-009 Cin  input  1  carry-in for add; ignored when SUB=1.
REQ-010 busy  output  1  operation in progress.
REQ-011 done  output  1  one-cycle pulse: result valid.
REQ-012 S  output  WIDTH  sum/difference.
REQ-013 Cout  output  1  carry out of MSB (for SUB: 1 = no borrow).
REQ-014 OVF  output  1  two's-complement signed overflow.

Function
REQ-015 FSM states SHALL be IDLE, RUN, DONE.
REQ-016 Accept = start=1 at a rising edge while state is IDLE or DONE.
- Captures A, B, SUB and effective carry-in.
- Clears the chunk counter.
- Moves to RUN.
REQ-017 Effective operation:
- SUB=0: A + B + Cin.
- SUB=1: A + ~B + 1, with Cin ignored.
REQ-018 Each RUN edge adds the BPC least-significant unprocessed bits through BPC chained full-adder cells.
- Carry between chunks is held in a carry register.
- Result bits are shifted into the S register, LSB first.
REQ-019 Latency: with accept at edge t0 and N = WIDTH/BPC, the FSM enters DONE at edge t0+N.
- busy=1 for the N cycles after t0.
- done=1 for exactly the one cycle after edge t0+N.
REQ-020 In DONE:
- start=1 is accepted (back-to-back operation, no idle cycle).
- Otherwise the FSM returns to IDLE at the next edge.
REQ-021 S, Cout and OVF SHALL be valid when done=1 and held stable until the next accept.
- S SHALL NOT show partial results while busy=1; the internal shift register is separate from the S output.
REQ-022 OVF SHALL equal carry-into-MSB XOR carry-out-of-MSB of the final chunk.
REQ-023 start=1 while busy=1 SHALL be ignored; operands are not re-captured and timing is unaffected.
REQ-024 No width growth: the result is truncated to WIDTH; the extra bit is reported only on Cout.

Reset
REQ-025 rst_n=0 at a rising edge SHALL force, regardless of state including mid-RUN:
- state IDLE, counter 0, carry register 0;
- busy=0, done=0, S=0, Cout=0, OVF=0.
REQ-026 An aborted operation SHALL produce no done pulse.
REQ-027 A start seen in the same cycle that rst_n=0 SHALL be ignored.

Structure
REQ-028 Shared package adder_pkg SHALL hold:
- the state enum type (IDLE, RUN, DONE);
- a function computing the counter width, $clog2(WIDTH/BPC).
REQ-029 Sub-module FA1 (1-bit full adder: A, B, Cin -> S, Cout) SHALL be instantiated BPC times in a generate loop.
- No behavioural "+" SHALL be used on the datapath.

Verification
REQ-030 Benches SHALL run at WIDTH=8, BPC=1 unless stated, and cover these directed scenarios:
- A=0x0F, B=0x01, Cin=0, SUB=0 -> S=0x10, Cout=0, OVF=0; done exactly 8 cycles after accept edge.
- A=0xFF, B=0x01, Cin=1 -> S=0x01, Cout=1, OVF=0. A=0x7F, B=0x01 -> S=0x80, OVF=1.
- SUB=1, A=0x05, B=0x07, Cin=1 -> S=0xFE, Cout=0, OVF=0. SUB=1, A=0x80, B=0x01 -> S=0x7F, Cout=1, OVF=1.
- start pulsed 3 cycles into RUN with different operands -> ignored; first result unchanged, done at original cycle.
- rst_n=0 at cycle 4 of RUN -> all outputs 0 next cycle, no done; a fresh start then completes normally.
- WIDTH=8, BPC=4: back-to-back start held high -> done every 3 cycles; exhaustive 4-bit sweep at WIDTH=4 matches A+B+Cin.
